lr_predict_sequencer: RTL and testbench

//  Controller for linear_regression_prediction (y = theta0 + theta1*x). On i_start it walks
//  i_num_samples x-values out of a sample RAM and streams them into the datapath. It holds

---
 rtl/lr_pkg.sv | 21 ++
 rtl/lr_result_fifo.sv | 61 ++++++
 rtl/lr_predict_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_lr_predict_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lr_pkg.sv
// rtl/lr_pkg.sv - shared widths, FSM encoding and count clamp for the prediction sequencer
package lr_pkg;

  localparam int N      = 32;
  localparam int DEPTH  = 6686;
  localparam int ADDR_W = 13;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_TH = 3'd1,
    RUN     = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_e;

  // A run never walks past the end of the sample RAM.
  function automatic logic [ADDR_W-1:0] clamp_count(input logic [ADDR_W-1:0] n);
    return (n > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH) : n;
  endfunction

endpackage

// File: rtl/lr_result_fifo.sv
// rtl/lr_result_fifo.sv - synchronous result skid FIFO with occupancy count and drop flag
module lr_result_fifo #(
  parameter int W = 45,
  parameter int D = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   wr_en_i,
  input  logic [W-1:0]           wr_data_i,
  input  logic                   rd_en_i,
  output logic [W-1:0]           rd_data_o,
  output logic                   empty_o,
  output logic [$clog2(D):0]     count_o,
  output logic                   drop_o
);

  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D) + 1;

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, do_wr, do_rd;

  // A pop in the same cycle frees the slot, so a write to a full FIFO is only dropped without one.
  assign full      = (count_q == CW'(D));
  assign do_rd     = rd_en_i && (count_q != '0);
  assign do_wr     = wr_en_i && (!full || do_rd);
  assign drop_o    = wr_en_i && !do_wr;
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers and count; flush empties the FIFO in one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lr_predict_sequencer.sv
// rtl/lr_predict_sequencer.sv - walks sample RAM through the regression datapath into a result stream
module lr_predict_sequencer
  import lr_pkg::*;
#(
  parameter int DP_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_num_samples,
  input  logic [N-1:0]      i_theta0,
  input  logic [N-1:0]      i_theta1,
  input  logic              i_theta_vld,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic              o_x_rd_en,
  output logic [ADDR_W-1:0] o_x_rd_addr,
  input  logic [N-1:0]      i_x_rd_data,
  output logic [N-1:0]      o_dp_x,
  output logic              o_dp_x_vld,
  output logic [N-1:0]      o_dp_theta0,
  output logic [N-1:0]      o_dp_theta1,
  output logic              o_dp_theta_vld,
  input  logic [N-1:0]      i_dp_y,
  input  logic              i_dp_y_vld,
  output logic [N-1:0]      o_y_data,
  output logic [ADDR_W-1:0] o_y_idx,
  output logic              o_y_vld,
  input  logic              i_y_rdy
);

  localparam int CW = $clog2(FIFO_D) + 1;
  localparam int FW = N + ADDR_W;

  state_e                        state_q, state_d;
  logic [N-1:0]                  theta0_q, theta1_q;
  logic                          theta_loaded_q;
  logic [ADDR_W-1:0]             n_q, rd_addr_q, out_cnt_q, out_cnt_d;
  logic [CW-1:0]                 inflight_q, inflight_d;
  logic                          overflow_q;
  logic [DP_LAT:0]               tag_vld_q;
  logic [DP_LAT:0][ADDR_W-1:0]   tag_q;

  logic                          start_go, abort_go, theta_cap;
  logic                          rd_en, push, pop;
  logic [CW-1:0]                 fifo_count;
  logic                          fifo_empty, fifo_drop;
  logic [FW-1:0]                 fifo_rd_data;
  logic [CW:0]                   occupancy;

  assign start_go  = (state_q == IDLE) && i_start && !i_abort;
  assign abort_go  = (state_q != IDLE) && i_abort;
  assign theta_cap = i_theta_vld && ((state_q == IDLE) || (state_q == WAIT_TH));

  // Credit check: every issued read owns a FIFO slot until its result is popped.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign rd_en     = (state_q == RUN) && (rd_addr_q < n_q) && (occupancy < (CW+1)'(FIFO_D));

  // Only results whose tag is still live may enter; the tag pipe is wiped on abort.
  assign push      = i_dp_y_vld && tag_vld_q[DP_LAT];
  assign pop       = !fifo_empty && i_y_rdy;
  assign out_cnt_d = out_cnt_q + ADDR_W'(pop);

  // Reads issued minus results pushed.
  always_comb begin
    inflight_d = inflight_q + CW'(rd_en) - CW'(push);
  end

  // Run sequencing; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_go) begin
          if (clamp_count(i_num_samples) == '0) state_d = DONE;
          else if (theta_loaded_q)              state_d = RUN;
          else                                  state_d = WAIT_TH;
        end
      end
      WAIT_TH: if (i_theta_vld || theta_loaded_q)                    state_d = RUN;
      RUN:     if (rd_en && (rd_addr_q == n_q - ADDR_W'(1)))          state_d = DRAIN;
      DRAIN:   if (out_cnt_d == n_q)                                  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_go) state_d = IDLE;
  end

  // FSM state, run counters and the sticky overflow flag.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      rd_addr_q  <= '0;
      out_cnt_q  <= '0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_go) begin
        n_q        <= clamp_count(i_num_samples);
        rd_addr_q  <= '0;
        out_cnt_q  <= '0;
        inflight_q <= '0;
        overflow_q <= 1'b0;
      end else if (abort_go) begin
        inflight_q <= '0;
      end else begin
        if (rd_en) rd_addr_q <= rd_addr_q + ADDR_W'(1);
        out_cnt_q  <= out_cnt_d;
        inflight_q <= inflight_d;
        if (fifo_drop) overflow_q <= 1'b1;
      end
    end
  end

  // Theta capture; frozen once a run is streaming, kept across runs and aborts.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      theta0_q       <= '0;
      theta1_q       <= '0;
      theta_loaded_q <= 1'b0;
    end else if (theta_cap) begin
      theta0_q       <= i_theta0;
      theta1_q       <= i_theta1;
      theta_loaded_q <= 1'b1;
    end
  end

  // Index tags follow the data: stage 0 lines up with RAM data, stage DP_LAT with the result.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      tag_vld_q <= '0;
      tag_q     <= '0;
    end else if (abort_go) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q[0] <= rd_en;
      tag_q[0]     <= rd_addr_q;
      for (int j = 1; j <= DP_LAT; j++) begin
        tag_vld_q[j] <= tag_vld_q[j-1];
        tag_q[j]     <= tag_q[j-1];
      end
    end
  end

  lr_result_fifo #(
    .W (FW),
    .D (FIFO_D)
  ) u_fifo (
    .clk_i     (i_clock),
    .rst_ni    (i_reset),
    .flush_i   (abort_go),
    .wr_en_i   (push),
    .wr_data_i ({tag_q[DP_LAT], i_dp_y}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count),
    .drop_o    (fifo_drop)
  );

  assign o_busy         = (state_q == WAIT_TH) || (state_q == RUN) || (state_q == DRAIN);
  assign o_done         = (state_q == DONE);
  assign o_overflow     = overflow_q;
  assign o_x_rd_en      = rd_en;
  assign o_x_rd_addr    = rd_addr_q;
  assign o_dp_x         = tag_vld_q[0] ? i_x_rd_data : '0;
  assign o_dp_x_vld     = tag_vld_q[0];
  assign o_dp_theta0    = theta0_q;
  assign o_dp_theta1    = theta1_q;
  assign o_dp_theta_vld = theta_loaded_q;
  assign o_y_vld        = !fifo_empty;
  assign o_y_data       = o_y_vld ? fifo_rd_data[N-1:0] : '0;
  assign o_y_idx        = o_y_vld ? fifo_rd_data[FW-1:N] : '0;

endmodule

// File: tb/tb_lr_predict_sequencer.sv
// tb/tb_lr_predict_sequencer.sv - scoreboard bench for the regression prediction sequencer
module tb_lr_predict_sequencer;
  import lr_pkg::*;

  logic              i_clock = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_start = 1'b0;
  logic              i_abort = 1'b0;
  logic [ADDR_W-1:0] i_num_samples = '0;
  logic [N-1:0]      i_theta0 = '0;
  logic [N-1:0]      i_theta1 = '0;
  logic              i_theta_vld = 1'b0;
  logic              i_y_rdy = 1'b1;
  logic              o_busy, o_done, o_overflow, o_x_rd_en, o_dp_x_vld, o_dp_theta_vld, o_y_vld;
  logic [ADDR_W-1:0] o_x_rd_addr, o_y_idx;
  logic [N-1:0]      o_dp_x, o_dp_theta0, o_dp_theta1, o_y_data;
  logic [N-1:0]      ram_q = '0;
  logic [N-1:0]      dp_y_q = '0;
  logic              dp_vld_q = 1'b0;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [N-1:0]      y;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [N-1:0] xmem [0:63];
  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, issued = 0, popped = 0;
  int rdy_mode = 0, rdy_phase = 0;
  int d0, p0, k, base, occ, max_occ, snap;
  logic [N-1:0] th0, th1;

  lr_predict_sequencer dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_num_samples  (i_num_samples),
    .i_theta0       (i_theta0),
    .i_theta1       (i_theta1),
    .i_theta_vld    (i_theta_vld),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_overflow     (o_overflow),
    .o_x_rd_en      (o_x_rd_en),
    .o_x_rd_addr    (o_x_rd_addr),
    .i_x_rd_data    (ram_q),
    .o_dp_x         (o_dp_x),
    .o_dp_x_vld     (o_dp_x_vld),
    .o_dp_theta0    (o_dp_theta0),
    .o_dp_theta1    (o_dp_theta1),
    .o_dp_theta_vld (o_dp_theta_vld),
    .i_dp_y         (dp_y_q),
    .i_dp_y_vld     (dp_vld_q),
    .o_y_data       (o_y_data),
    .o_y_idx        (o_y_idx),
    .o_y_vld        (o_y_vld),
    .i_y_rdy        (i_y_rdy)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] ymodel(input logic [N-1:0] t0, input logic [N-1:0] t1,
                                          input logic [N-1:0] x);
    return t0 + t1 * x;
  endfunction

  function automatic logic [12:0] outs_vec();
    return {o_busy, o_done, o_overflow, o_x_rd_en, |o_x_rd_addr, |o_dp_x, o_dp_x_vld,
            |o_dp_theta0, |o_dp_theta1, o_dp_theta_vld, |o_y_data, |o_y_idx, o_y_vld};
  endfunction

  // Sample RAM: one-cycle read latency.
  always @(posedge i_clock) begin
    if (o_x_rd_en) ram_q <= xmem[o_x_rd_addr[5:0]];
  end

  // Datapath: y = theta0 + theta1*x, one-cycle latency.
  always @(posedge i_clock) begin
    dp_y_q   <= o_dp_theta0 + o_dp_theta1 * o_dp_x;
    dp_vld_q <= o_dp_x_vld;
  end

  // Consumer ready: always, or one cycle in three.
  always @(posedge i_clock) begin
    #1;
    rdy_phase = (rdy_phase + 1) % 3;
    i_y_rdy = (rdy_mode != 0) ? (rdy_phase == 0) : 1'b1;
  end

  // Monitor: count events and pop the scoreboard on each result transfer.
  always @(negedge i_clock) begin
    if (o_done) done_cnt++;
    if (o_x_rd_en) issued++;
    if (o_y_vld && i_y_rdy) begin
      popped++;
      if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
      else begin
        mon_e = sb.pop_front();
        check("y_data", o_y_data, mon_e.y);
        check("y_idx", o_y_idx, mon_e.idx);
      end
    end
  end

  task automatic push_exp(input int n, input logic [N-1:0] t0, input logic [N-1:0] t1);
    for (int i = 0; i < n; i++) sb.push_back('{idx: ADDR_W'(i), y: ymodel(t0, t1, xmem[i])});
  endtask

  task automatic load_theta(input logic [N-1:0] t0, input logic [N-1:0] t1);
    @(posedge i_clock); #1;
    i_theta0 = t0; i_theta1 = t1; i_theta_vld = 1'b1;
    @(posedge i_clock); #1;
    i_theta_vld = 1'b0;
  endtask

  task automatic start_run(input int n);
    @(posedge i_clock); #1;
    i_num_samples = ADDR_W'(n); i_start = 1'b1;
    @(posedge i_clock); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d;
    int c;
    d = done_cnt;
    c = 0;
    while (done_cnt == d && c < budget) begin
      @(posedge i_clock); #1;
      c++;
    end
    check(tag, done_cnt - d, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) xmem[i] = 32'(i * 3 + 1);
    i_reset = 1'b0;
    @(negedge i_clock);
    check("reset_outs", outs_vec(), 0);
    repeat (2) @(posedge i_clock); #1;
    i_reset = 1'b1;

    // Reset in the middle of a run.
    load_theta(32'd7, 32'd2);
    push_exp(8, 32'd7, 32'd2);
    start_run(8);
    repeat (3) @(posedge i_clock); #1;
    check("t1_busy", o_busy, 1);
    i_reset = 1'b0;
    #1;
    check("t1_rst_outs", outs_vec(), 0);
    repeat (2) @(posedge i_clock); #1;
    i_reset = 1'b1;
    sb.delete();

    // Start before thetas are loaded; thetas arrive five cycles later.
    xmem[0] = 32'd5; xmem[1] = 32'd6; xmem[2] = 32'd7; xmem[3] = 32'd8;
    push_exp(4, 32'd100, 32'd3);
    snap = issued;
    start_run(4);
    repeat (4) @(posedge i_clock); #1;
    i_theta0 = 32'd100; i_theta1 = 32'd3; i_theta_vld = 1'b1;
    check("t5_no_early_rd", issued - snap, 0);
    @(negedge i_clock);
    check("t5_rd_in_capture", o_x_rd_en, 0);
    @(posedge i_clock); #1;
    i_theta_vld = 1'b0;
    @(negedge i_clock);
    check("t5_first_rd", o_x_rd_en, 1);
    wait_done("t5_done", 100);
    check("t5_sb_empty", sb.size(), 0);

    // Known-answer run.
    load_theta(32'd69403, 32'd1111);
    xmem[0] = 32'd0; xmem[1] = 32'd1; xmem[2] = 32'd2; xmem[3] = 32'd10;
    sb.push_back('{idx: 13'd0, y: 32'd69403});
    sb.push_back('{idx: 13'd1, y: 32'd70514});
    sb.push_back('{idx: 13'd2, y: 32'd71625});
    sb.push_back('{idx: 13'd3, y: 32'd80513});
    d0 = done_cnt;
    start_run(4);
    wait_done("t2_done", 100);
    repeat (3) @(posedge i_clock); #1;
    check("t2_done_once", done_cnt - d0, 1);
    check("t2_sb_empty", sb.size(), 0);
    check("t2_overflow", o_overflow, 0);

    // Zero-sample run.
    snap = issued;
    start_run(0);
    @(negedge i_clock);
    check("t3_done_next", o_done, 1);
    @(posedge i_clock); #1;
    check("t3_no_reads", issued - snap, 0);

    // Sixteen samples with sparse consumer ready.
    th0 = $urandom; th1 = $urandom;
    for (int i = 0; i < 16; i++) xmem[i] = $urandom;
    load_theta(th0, th1);
    push_exp(16, th0, th1);
    rdy_mode = 1;
    d0 = done_cnt;
    base = issued - popped;
    max_occ = 0;
    k = 0;
    start_run(16);
    while (done_cnt == d0 && k < 2000) begin
      @(posedge i_clock); #1;
      k++;
      occ = issued - popped - base;
      if (occ > max_occ) max_occ = occ;
    end
    check("t4_done", done_cnt - d0, 1);
    rdy_mode = 0;
    check("t4_occ_within_fifo", (max_occ <= 4), 1);
    check("t4_overflow", o_overflow, 0);
    check("t4_sb_empty", sb.size(), 0);

    // Abort at the third result, then a short restart.
    push_exp(8, th0, th1);
    p0 = popped;
    d0 = done_cnt;
    k = 0;
    start_run(8);
    while ((popped - p0) < 3 && k < 200) begin
      @(posedge i_clock); #1;
      k++;
    end
    check("t6_third_result", (popped - p0) >= 3, 1);
    i_abort = 1'b1;
    @(posedge i_clock); #1;
    i_abort = 1'b0;
    sb.delete();
    @(negedge i_clock);
    check("t6_busy_clear", o_busy, 0);
    check("t6_fifo_flushed", o_y_vld, 0);
    repeat (5) @(posedge i_clock); #1;
    check("t6_no_done", done_cnt - d0, 0);
    push_exp(2, th0, th1);
    p0 = popped;
    start_run(2);
    wait_done("t6_restart_done", 100);
    check("t6_restart_count", popped - p0, 2);
    check("t6_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
